// File: rtl/cdf_scratch_responder_if.sv
// Bus bundle between the CDF controller/datapath, the scratch and result
// RAMs, and cdf_scratch_responder.
// The mono_err signal exists only when CDF_MONOTONIC_CHECK_EN is defined.
interface cdf_scratch_responder_if #(
  parameter int ADDR_W = 6,
  parameter int HIST_W = 16,
  parameter int CDF_W  = 20
) ();
  // Controller / datapath side
  logic              read_first_value;
  logic              read_next_value;
  logic              cdf_computation_done;
  logic [CDF_W-1:0]  cdf_value_in;
  // Scratch (histogram) RAM side
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr_a;
  logic [ADDR_W-1:0] mem_rd_addr_b;
  logic [HIST_W-1:0] mem_rd_data_a;
  logic [HIST_W-1:0] mem_rd_data_b;
  // Held bins towards the datapath
  logic [HIST_W-1:0] bin_even;
  logic [HIST_W-1:0] bin_odd;
  logic              bins_valid;
  // Result RAM side
  logic              cdf_wr_en;
  logic [ADDR_W-1:0] cdf_wr_addr;
  logic [CDF_W-1:0]  cdf_wr_data;
  // Status
  logic              pass_done;
  logic              image_done;
  logic              proto_err;
`ifdef CDF_MONOTONIC_CHECK_EN
  logic              mono_err;
`endif

  // Controller, datapath and RAM models drive the requests and read data.
  modport master (
    output read_first_value, read_next_value, cdf_computation_done, cdf_value_in,
    output mem_rd_data_a, mem_rd_data_b,
    input  mem_rd_en, mem_rd_addr_a, mem_rd_addr_b,
    input  bin_even, bin_odd, bins_valid,
    input  cdf_wr_en, cdf_wr_addr, cdf_wr_data,
    input  pass_done, image_done, proto_err
`ifdef CDF_MONOTONIC_CHECK_EN
    , input mono_err
`endif
  );

  // The responder itself.
  modport slave (
    input  read_first_value, read_next_value, cdf_computation_done, cdf_value_in,
    input  mem_rd_data_a, mem_rd_data_b,
    output mem_rd_en, mem_rd_addr_a, mem_rd_addr_b,
    output bin_even, bin_odd, bins_valid,
    output cdf_wr_en, cdf_wr_addr, cdf_wr_data,
    output pass_done, image_done, proto_err
`ifdef CDF_MONOTONIC_CHECK_EN
    , output mono_err
`endif
  );
endinterface

// File: rtl/cdf_scratch_responder.sv
// cdf_scratch_responder: fetches even/odd histogram bin pairs from scratch
// RAM for the CDF datapath and writes the two resulting CDF values back to
// the result RAM, tracking the bin base address internally.
// Optional: define CDF_MONOTONIC_CHECK_EN to add a sticky mono_err flag that
// fires when a written CDF value is smaller than the previously written one.
module cdf_scratch_responder #(
  parameter int NUM_BINS = 64,
  parameter int ADDR_W   = 6,
  parameter int HIST_W   = 16,
  parameter int CDF_W    = 20
) (
  input logic                    clk,
  input logic                    reset,
  cdf_scratch_responder_if.slave bus
);

  // Base is one bit wider than a bin address so that stepping past the last
  // pair lands on a value >= NUM_BINS instead of wrapping back to 0.
  localparam int                BASE_W     = ADDR_W + 1;
  localparam logic [BASE_W-1:0] NUM_BINS_C = BASE_W'(NUM_BINS);
  localparam logic [BASE_W-1:0] LAST_BIN_C = BASE_W'(NUM_BINS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_HOLD2   = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [BASE_W-1:0] base_r, base_s;
  logic              wr_sel_r, wr_sel_s;
  logic              pass_ok_r, pass_ok_s;
  logic              mem_rd_en_r, mem_rd_en_s;
  logic [ADDR_W-1:0] mem_rd_addr_a_r, mem_rd_addr_a_s;
  logic [ADDR_W-1:0] mem_rd_addr_b_r, mem_rd_addr_b_s;
  logic [HIST_W-1:0] bin_even_r, bin_even_s;
  logic [HIST_W-1:0] bin_odd_r, bin_odd_s;
  logic              bins_valid_r, bins_valid_s;
  logic              cdf_wr_en_r, cdf_wr_en_s;
  logic [ADDR_W-1:0] cdf_wr_addr_r, cdf_wr_addr_s;
  logic [CDF_W-1:0]  cdf_wr_data_r, cdf_wr_data_s;
  logic              pass_done_r, pass_done_s;
  logic              image_done_r, image_done_s;
  logic              proto_err_r, proto_err_s;

  logic              in_idle_s;
  logic              overrun_s;
  logic [BASE_W-1:0] base_p1_s;
  logic [BASE_W-1:0] base_p2_s;
  logic              first_err_s;
  logic              next_ok_s;
  logic              next_err_s;
  logic              done_err_s;
  logic              start_s;
  logic [BASE_W-1:0] start_base_s;
  logic [ADDR_W-1:0] wr_addr_s;

  assign in_idle_s   = (state_r == ST_IDLE);
  assign overrun_s   = (base_r >= NUM_BINS_C);
  assign base_p1_s   = base_r + BASE_W'(1);
  assign base_p2_s   = base_r + BASE_W'(2);
  assign wr_addr_s   = base_r[ADDR_W-1:0] + ADDR_W'(wr_sel_r);

  // read_first_value is always honoured; outside IDLE it is still flagged.
  assign first_err_s = bus.read_first_value && !in_idle_s;
  // read_next_value only continues an image from IDLE after a finished pass.
  assign next_ok_s   = !bus.read_first_value && bus.read_next_value && in_idle_s && pass_ok_r;
  assign next_err_s  = !bus.read_first_value && bus.read_next_value && !(in_idle_s && pass_ok_r);
  // Results are only meaningful once the bins are held.
  assign done_err_s  = bus.cdf_computation_done &&
                       ((state_r == ST_IDLE) || (state_r == ST_FETCH) || (state_r == ST_CAPTURE));

  // Next-state and next-output computation for the fetch/hold/write sequence.
  always_comb begin
    state_s         = state_r;
    base_s          = base_r;
    wr_sel_s        = wr_sel_r;
    pass_ok_s       = pass_ok_r;
    mem_rd_en_s     = 1'b0;
    mem_rd_addr_a_s = '0;
    mem_rd_addr_b_s = '0;
    bin_even_s      = bin_even_r;
    bin_odd_s       = bin_odd_r;
    bins_valid_s    = bins_valid_r;
    cdf_wr_en_s     = 1'b0;
    cdf_wr_addr_s   = cdf_wr_addr_r;
    cdf_wr_data_s   = cdf_wr_data_r;
    pass_done_s     = 1'b0;
    image_done_s    = 1'b0;
    proto_err_s     = proto_err_r | first_err_s | next_err_s | done_err_s;
    start_s         = 1'b0;
    start_base_s    = base_r;

    if (bus.read_first_value) begin
      start_s      = 1'b1;
      start_base_s = '0;
    end else if (next_ok_s) begin
      start_s      = 1'b1;
      // Once past the end, stay parked there rather than walk towards a wrap.
      start_base_s = overrun_s ? base_r : base_p2_s;
    end else begin
      start_s      = 1'b0;
    end

    if (start_s) begin
      state_s      = ST_FETCH;
      base_s       = start_base_s;
      wr_sel_s     = 1'b0;
      pass_ok_s    = 1'b0;
      bins_valid_s = 1'b0;
      if (start_base_s < NUM_BINS_C) begin
        mem_rd_en_s     = 1'b1;
        mem_rd_addr_a_s = start_base_s[ADDR_W-1:0];
        mem_rd_addr_b_s = start_base_s[ADDR_W-1:0] + ADDR_W'(1);
      end else begin
        mem_rd_en_s     = 1'b0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_FETCH: begin
          state_s = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // RAM data for the address issued in FETCH is valid this cycle.
          state_s      = ST_HOLD;
          bins_valid_s = 1'b1;
          if (overrun_s) begin
            bin_even_s = '0;
            bin_odd_s  = '0;
          end else begin
            bin_even_s = bus.mem_rd_data_a;
            bin_odd_s  = bus.mem_rd_data_b;
          end
        end
        ST_HOLD: begin
          if (bus.cdf_computation_done) begin
            state_s     = ST_HOLD2;
            wr_sel_s    = 1'b1;
            cdf_wr_en_s = !overrun_s;
            if (!overrun_s) begin
              cdf_wr_addr_s = wr_addr_s;
              cdf_wr_data_s = bus.cdf_value_in;
            end else begin
              cdf_wr_addr_s = cdf_wr_addr_r;
            end
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_HOLD2: begin
          if (bus.cdf_computation_done) begin
            state_s      = ST_IDLE;
            wr_sel_s     = 1'b0;
            bins_valid_s = 1'b0;
            pass_done_s  = 1'b1;
            pass_ok_s    = 1'b1;
            image_done_s = (base_p1_s == LAST_BIN_C);
            cdf_wr_en_s  = !overrun_s;
            if (!overrun_s) begin
              cdf_wr_addr_s = wr_addr_s;
              cdf_wr_data_s = bus.cdf_value_in;
            end else begin
              cdf_wr_addr_s = cdf_wr_addr_r;
            end
          end else begin
            state_s = ST_HOLD2;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bookkeeping and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      base_r          <= '0;
      wr_sel_r        <= 1'b0;
      pass_ok_r       <= 1'b0;
      mem_rd_en_r     <= 1'b0;
      mem_rd_addr_a_r <= '0;
      mem_rd_addr_b_r <= '0;
      bin_even_r      <= '0;
      bin_odd_r       <= '0;
      bins_valid_r    <= 1'b0;
      cdf_wr_en_r     <= 1'b0;
      cdf_wr_addr_r   <= '0;
      cdf_wr_data_r   <= '0;
      pass_done_r     <= 1'b0;
      image_done_r    <= 1'b0;
      proto_err_r     <= 1'b0;
    end else begin
      base_r          <= base_s;
      wr_sel_r        <= wr_sel_s;
      pass_ok_r       <= pass_ok_s;
      mem_rd_en_r     <= mem_rd_en_s;
      mem_rd_addr_a_r <= mem_rd_addr_a_s;
      mem_rd_addr_b_r <= mem_rd_addr_b_s;
      bin_even_r      <= bin_even_s;
      bin_odd_r       <= bin_odd_s;
      bins_valid_r    <= bins_valid_s;
      cdf_wr_en_r     <= cdf_wr_en_s;
      cdf_wr_addr_r   <= cdf_wr_addr_s;
      cdf_wr_data_r   <= cdf_wr_data_s;
      pass_done_r     <= pass_done_s;
      image_done_r    <= image_done_s;
      proto_err_r     <= proto_err_s;
    end
  end

  assign bus.mem_rd_en     = mem_rd_en_r;
  assign bus.mem_rd_addr_a = mem_rd_addr_a_r;
  assign bus.mem_rd_addr_b = mem_rd_addr_b_r;
  assign bus.bin_even      = bin_even_r;
  assign bus.bin_odd       = bin_odd_r;
  assign bus.bins_valid    = bins_valid_r;
  assign bus.cdf_wr_en     = cdf_wr_en_r;
  assign bus.cdf_wr_addr   = cdf_wr_addr_r;
  assign bus.cdf_wr_data   = cdf_wr_data_r;
  assign bus.pass_done     = pass_done_r;
  assign bus.image_done    = image_done_r;
  assign bus.proto_err     = proto_err_r;

`ifdef CDF_MONOTONIC_CHECK_EN
  logic [CDF_W-1:0] last_cdf_r;
  logic             mono_err_r;

  // Remember the last written CDF value and flag any write that goes down.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_cdf_r <= '0;
      mono_err_r <= 1'b0;
    end else begin
      if (bus.read_first_value) begin
        last_cdf_r <= '0;
      end else if (cdf_wr_en_s) begin
        last_cdf_r <= cdf_wr_data_s;
        if (cdf_wr_data_s < last_cdf_r) begin
          mono_err_r <= 1'b1;
        end else begin
          mono_err_r <= mono_err_r;
        end
      end else begin
        last_cdf_r <= last_cdf_r;
      end
    end
  end

  assign bus.mono_err = mono_err_r;
`endif

endmodule

// File: tb/tb_cdf_scratch_responder.sv
// Self-checking bench for cdf_scratch_responder: scratch RAM model with
// 1-cycle latency, write scoreboard, and one task per scenario.
module tb_cdf_scratch_responder;
  localparam int NUM_BINS = 64;
  localparam int ADDR_W   = 6;
  localparam int HIST_W   = 16;
  localparam int CDF_W    = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [HIST_W-1:0]       hist_mem [0:NUM_BINS-1];
  logic [ADDR_W+CDF_W-1:0] sb_q [$];

  cdf_scratch_responder_if #(.ADDR_W(ADDR_W), .HIST_W(HIST_W), .CDF_W(CDF_W)) bus ();

  cdf_scratch_responder #(
    .NUM_BINS(NUM_BINS), .ADDR_W(ADDR_W), .HIST_W(HIST_W), .CDF_W(CDF_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scratch RAM model: 1-cycle read latency on both ports.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_data_a <= hist_mem[bus.mem_rd_addr_a];
      bus.mem_rd_data_b <= hist_mem[bus.mem_rd_addr_b];
    end
  end

  // Result-RAM scoreboard: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.cdf_wr_en === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write",
                 bus.cdf_wr_addr, bus.cdf_wr_data);
      end else begin
        logic [ADDR_W+CDF_W-1:0] exp_w;
        exp_w = sb_q.pop_front();
        if ({bus.cdf_wr_addr, bus.cdf_wr_data} !== exp_w) begin
          failures++;
          $display("FAIL write_content: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   bus.cdf_wr_addr, bus.cdf_wr_data, exp_w[ADDR_W+CDF_W-1:CDF_W], exp_w[CDF_W-1:0]);
        end
      end
    end
  end

  // One-cycle request pulse; returns at the negedge after the sampling edge.
  task automatic pulse(input bit f, input bit n, input bit d, input logic [CDF_W-1:0] v);
    @(negedge clk);
    bus.read_first_value     = f;
    bus.read_next_value      = n;
    bus.cdf_computation_done = d;
    bus.cdf_value_in         = v;
    @(negedge clk);
    bus.read_first_value     = 1'b0;
    bus.read_next_value      = 1'b0;
    bus.cdf_computation_done = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // A full pass: fetch at base, check held bins, two result writes.
  task automatic do_pass(input bit first, input int base,
                         input logic [HIST_W-1:0] e, input logic [HIST_W-1:0] o,
                         input logic [CDF_W-1:0] v0, input logic [CDF_W-1:0] v1,
                         input bit exp_img);
    bit ovr;
    ovr = (base >= NUM_BINS);
    if (!ovr) begin
      hist_mem[base]     = e;
      hist_mem[base + 1] = o;
    end
    pulse(first, !first, 1'b0, '0);
    checks++;
    if (bus.mem_rd_en !== !ovr) begin
      failures++; $display("FAIL rd_en base=%0d: got %0b, required %0b", base, bus.mem_rd_en, !ovr);
    end
    if (!ovr) begin
      checks++;
      if (bus.mem_rd_addr_a !== ADDR_W'(base) || bus.mem_rd_addr_b !== ADDR_W'(base + 1)) begin
        failures++; $display("FAIL rd_addr base=%0d: got %0d/%0d, required %0d/%0d",
                             base, bus.mem_rd_addr_a, bus.mem_rd_addr_b, base, base + 1);
      end
    end
    checks++;
    if (bus.bins_valid !== 1'b0) begin
      failures++; $display("FAIL valid_t1 base=%0d: got %0b, required 0", base, bus.bins_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.bins_valid !== 1'b0) begin
      failures++; $display("FAIL valid_t2 base=%0d: got %0b, required 0", base, bus.bins_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.bins_valid !== 1'b1 || bus.bin_even !== (ovr ? '0 : e) || bus.bin_odd !== (ovr ? '0 : o)) begin
      failures++; $display("FAIL bins base=%0d: got v=%0b %0d/%0d, required v=1 %0d/%0d", base,
                           bus.bins_valid, bus.bin_even, bus.bin_odd, ovr ? 0 : e, ovr ? 0 : o);
    end
    if (!ovr) sb_q.push_back({ADDR_W'(base), v0});
    pulse(1'b0, 1'b0, 1'b1, v0);
    checks++;
    if (bus.cdf_wr_en !== !ovr || bus.pass_done !== 1'b0) begin
      failures++; $display("FAIL first_write base=%0d: got wr=%0b pd=%0b, required wr=%0b pd=0",
                           base, bus.cdf_wr_en, bus.pass_done, !ovr);
    end
    @(negedge clk);
    checks++;
    if (bus.cdf_wr_en !== 1'b0 || bus.bins_valid !== 1'b1) begin
      failures++; $display("FAIL wr_width base=%0d: got wr=%0b v=%0b, required wr=0 v=1",
                           base, bus.cdf_wr_en, bus.bins_valid);
    end
    if (!ovr) sb_q.push_back({ADDR_W'(base + 1), v1});
    pulse(1'b0, 1'b0, 1'b1, v1);
    checks++;
    if (bus.pass_done !== 1'b1 || bus.image_done !== exp_img || bus.bins_valid !== 1'b0
        || bus.cdf_wr_en !== !ovr) begin
      failures++; $display("FAIL pass_end base=%0d: got pd=%0b img=%0b v=%0b wr=%0b, required 1/%0b/0/%0b",
                           base, bus.pass_done, bus.image_done, bus.bins_valid, bus.cdf_wr_en, exp_img, !ovr);
    end
    @(negedge clk);
    checks++;
    if (bus.pass_done !== 1'b0 || bus.image_done !== 1'b0) begin
      failures++; $display("FAIL pass_pulse base=%0d: got pd=%0b img=%0b, required 0/0",
                           base, bus.pass_done, bus.image_done);
    end
  endtask

  task automatic test_reset();
    bus.read_first_value = 1'b0; bus.read_next_value = 1'b0;
    bus.cdf_computation_done = 1'b0; bus.cdf_value_in = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_rd_en, bus.mem_rd_addr_a, bus.mem_rd_addr_b, bus.bin_even, bus.bin_odd, bus.bins_valid,
         bus.cdf_wr_en, bus.cdf_wr_addr, bus.cdf_wr_data, bus.pass_done, bus.image_done, bus.proto_err} !== '0) begin
      failures++; $display("FAIL reset_outputs: got nonzero output, required all 0");
    end
    reset = 1'b1;
  endtask

  task automatic test_first_pass();
    do_pass(1'b1, 0, 16'd5, 16'd7, 20'd5, 20'd12, 1'b0);
    checks++;
    if (bus.proto_err !== 1'b0) begin
      failures++; $display("FAIL first_pass_err: got %0b, required 0", bus.proto_err);
    end
  endtask

  task automatic test_full_image();
    for (int p = 1; p < NUM_BINS / 2; p++) begin
      do_pass(1'b0, 2 * p, HIST_W'(p * 5 + 1), HIST_W'(p * 5 + 3),
              CDF_W'(p * 100), CDF_W'(p * 100 + 50), (p == NUM_BINS / 2 - 1));
    end
    checks++;
    if (bus.proto_err !== 1'b0) begin
      failures++; $display("FAIL full_image_err: got %0b, required 0", bus.proto_err);
    end
  endtask

  task automatic test_overrun();
    do_pass(1'b0, NUM_BINS, 16'd0, 16'd0, 20'd77, 20'd78, 1'b0);
  endtask

  task automatic test_proto_err();
    apply_reset();
    pulse(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (bus.proto_err !== 1'b1 || bus.mem_rd_en !== 1'b0) begin
      failures++; $display("FAIL next_no_pass: got err=%0b rd=%0b, required 1/0", bus.proto_err, bus.mem_rd_en);
    end
    apply_reset();
    checks++;
    if (bus.proto_err !== 1'b0) begin
      failures++; $display("FAIL err_reset_clear: got %0b, required 0", bus.proto_err);
    end
    pulse(1'b0, 1'b0, 1'b1, 20'd99);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.proto_err !== 1'b1 || bus.cdf_wr_en !== 1'b0) begin
      failures++; $display("FAIL done_in_idle: got err=%0b wr=%0b, required 1/0", bus.proto_err, bus.cdf_wr_en);
    end
    hist_mem[0] = 16'd21; hist_mem[1] = 16'd22;
    pulse(1'b1, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    pulse(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (bus.proto_err !== 1'b1 || bus.mem_rd_en !== 1'b0 || bus.bins_valid !== 1'b1 || bus.bin_even !== 16'd21) begin
      failures++; $display("FAIL next_in_hold: got err=%0b rd=%0b v=%0b be=%0d, required 1/0/1/21",
                           bus.proto_err, bus.mem_rd_en, bus.bins_valid, bus.bin_even);
    end
    sb_q.push_back({ADDR_W'(0), 20'd30});
    pulse(1'b0, 1'b0, 1'b1, 20'd30);
    sb_q.push_back({ADDR_W'(1), 20'd40});
    pulse(1'b0, 1'b0, 1'b1, 20'd40);
    checks++;
    if (bus.pass_done !== 1'b1 || bus.proto_err !== 1'b1) begin
      failures++; $display("FAIL err_sticky: got pd=%0b err=%0b, required 1/1", bus.pass_done, bus.proto_err);
    end
    pulse(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (bus.mem_rd_en !== 1'b1) begin
      failures++; $display("FAIL fetch_before_reset: got %0b, required 1", bus.mem_rd_en);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_rd_en, bus.mem_rd_addr_b, bus.bin_even, bus.bin_odd, bus.bins_valid,
         bus.cdf_wr_en, bus.cdf_wr_data, bus.pass_done, bus.image_done, bus.proto_err} !== '0) begin
      failures++; $display("FAIL reset_mid_fetch: got rd=%0b err=%0b be=%0d, required all 0",
                           bus.mem_rd_en, bus.proto_err, bus.bin_even);
    end
    reset = 1'b1;
  endtask

  task automatic test_priority();
    apply_reset();
    hist_mem[0] = 16'd3; hist_mem[1] = 16'd4;
    pulse(1'b1, 1'b1, 1'b0, '0);
    checks++;
    if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr_a !== 6'd0 || bus.proto_err !== 1'b0) begin
      failures++; $display("FAIL first_beats_next: got rd=%0b a=%0d err=%0b, required 1/0/0",
                           bus.mem_rd_en, bus.mem_rd_addr_a, bus.proto_err);
    end
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr_a !== 6'd0 || bus.bins_valid !== 1'b0 || bus.proto_err !== 1'b1) begin
      failures++; $display("FAIL restart_in_hold: got rd=%0b a=%0d v=%0b err=%0b, required 1/0/0/1",
                           bus.mem_rd_en, bus.mem_rd_addr_a, bus.bins_valid, bus.proto_err);
    end
    apply_reset();
  endtask

`ifdef CDF_MONOTONIC_CHECK_EN
  task automatic test_mono();
    apply_reset();
    checks++;
    if (bus.mono_err !== 1'b0) begin
      failures++; $display("FAIL mono_reset: got %0b, required 0", bus.mono_err);
    end
    do_pass(1'b1, 0, 16'd1, 16'd2, 20'd10, 20'd9, 1'b0);
    checks++;
    if (bus.mono_err !== 1'b1) begin
      failures++; $display("FAIL mono_err: got %0b, required 1", bus.mono_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_pass();
    test_full_image();
    test_overrun();
    test_proto_err();
    test_priority();
`ifdef CDF_MONOTONIC_CHECK_EN
    test_mono();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL missing_writes: got %0d pending, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
